music_tone_gen: RTL
===================

Name: music_tone_gen

Overview:
- Multi-channel square-wave tone generator. It replaces the fixed single-channel note-to-period lookup with chromatic notes, parametrised octaves and channels, and free-running period counters.
- Each channel accepts note codes through a valid/ready handshake. Note changes are applied glitch-free at period boundaries.
- Sits between the song sequencer and the speaker/PWM output stage of the music subsystem.

Parameters:
- CLK_FRE, 50_000_000, system clock frequency in Hz.
- CHANNELS, 2, number of independent tone channels (1..8).
- OCTAVES, 4, number of supported octaves (1..8); octave 0 is the base octave.
- PERIOD_W, 20, width of the period counter; must hold CLK_FRE/261.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- note_code, in, 8*CHANNELS, per-channel note code, {octave[3:0], semitone[3:0]}.
- note_valid, in, CHANNELS, per-channel load request.
- note_ready, out, CHANNELS, per-channel pending slot free.
- mute, in, 1, forces tone_out low; counters keep running.
- tone_out, out, CHANNELS, per-channel square wave.
- active, out, CHANNELS, channel in PLAY state.
- mix_out, out, $clog2(CHANNELS+1), count of channels whose tone_out is high.

Behaviour:
- Reset and clocking:
  - One clock; reset is synchronous and active-low.
  - On rst_n=0 at a clk edge, all registers clear: tone_out=0, active=0, mix_out=0, note_ready all 1, pending slots empty, counters 0.
- Note decode:
  - Semitone 1..12 maps to C..B using the package base table {261,277,293,311,329,349,369,392,415,440,466,493} Hz.
  - period = (CLK_FRE / base_hz) >> octave, computed at elaboration as a localparam array. Integer division truncates.
  - Code 0x00, semitone 0 or 13..15, or octave >= OCTAVES decodes as REST.
- Handshake:
  - Transfer occurs when note_valid & note_ready at a clk edge. The decoded period, or REST, is stored in that channel's pending slot.
  - note_ready = pending slot empty.
  - Holding note_valid while note_ready=0 has no effect; no overwrite of the pending slot.
- Per-channel FSM, IDLE -> PLAY:
  - IDLE: counter held at 0, tone_out=0, active=0.
    - If the pending slot holds a non-REST period, load it, clear pending, and enter PLAY with cnt=0.
    - A pending REST in IDLE is simply cleared.
    - A slot accepted at edge k is consumed at edge k+1, so tone_out first goes high at edge k+1.
  - PLAY: cnt increments each cycle; wrap when cnt == period-1.
    - tone_out = (cnt < period>>1) & ~mute. This gives 50% duty; for odd periods the low phase is one cycle longer.
    - At wrap with pending non-REST: load the new period, cnt=0, clear pending.
    - At wrap with pending REST: enter IDLE, clear pending.
    - At wrap with no pending: repeat the same period.
    - A transfer on the same edge as a wrap is not applied at that wrap; it waits for the next wrap.
- Output register:
  - mix_out is registered: popcount of the tone_out values for the same cycle, one cycle later.
  - mute affects mix_out identically.
- Reset mid-operation: immediate return to the reset state; pending notes are discarded.

Optional Feature:
- Macro MUSIC_TONE_DUTY_EN.
- When defined:
  - Extra input duty_sel (2*CHANNELS), captured into the pending slot with the note.
  - Duty selects: 0 = period>>3, 1 = period>>2, 2 = period>>1, 3 = period - (period>>2).
  - tone_out = cnt < threshold.
- When undefined: no port; fixed 50% duty as above.

Decomposition:
- Package music_pkg holds:
  - the base frequency constant array;
  - the note-code field widths and REST encoding;
  - the duty encoding;
  - a constant function computing a period from CLK_FRE, semitone and octave.
- One sub-module, music_tone_chan, per channel: pending slot, FSM, counter, duty compare.
- The top level instantiates CHANNELS copies and the registered popcount.

Test Plan (CLK_FRE=44_000, CHANNELS=2, OCTAVES=4):
- Reset, then load 0x0A on ch0 -> active[0]=1 the next cycle; tone_out[0] high 50 cycles / low 50 cycles repeating (period 100).
- While playing 0x0A, load 0x1A mid-period -> current 100-cycle period completes; then 25 high / 25 low; note_ready[0] low until the wrap.
- Load 0x00 while playing -> tone stops at the next wrap, active=0. Load 0x0D or 0x4A -> treated as REST.
- Ch0=0x0A and ch1=0x01 (period 168, 84/84) -> mix_out toggles among 0, 1 and 2, matching the popcount of tone_out one cycle earlier. Assert mute -> tone_out=0 and mix_out=0 one cycle later; phase is preserved on release.
- Second note_valid while note_ready=0 -> ignored; the first pending note is applied at the wrap.
- rst_n=0 mid-period with a pending note -> all outputs 0, note_ready=all 1, no tone after release until a new load.
- With MUSIC_TONE_DUTY_EN: 0x0A with duty 1 -> 25 high / 75 low.

Source files
------------

// File: rtl/music_pkg.sv
// Shared constants for the music tone generator: note-code layout, base pitch
// table, duty encoding, channel FSM states and the period helper.
package music_pkg;

  // Note code layout: {octave[3:0], semitone[3:0]}
  localparam int unsigned SemiW = 4;
  localparam int unsigned OctW  = 4;
  localparam int unsigned CodeW = SemiW + OctW;

  // Code 0x00 is the canonical REST; semitone 0 or 13..15 also rests
  localparam logic [CodeW-1:0] RestCode = 8'h00;
  localparam logic [SemiW-1:0] SemiRest = 4'd0;
  localparam int unsigned      NumSemis = 12;

  // Octave-0 base frequencies in Hz, C..B
  localparam int unsigned BaseHz [NumSemis] = '{261, 277, 293, 311, 329, 349,
                                                369, 392, 415, 440, 466, 493};

  // Duty selector encoding (MUSIC_TONE_DUTY_EN builds only)
  localparam int unsigned DutyW = 2;
  typedef enum logic [DutyW-1:0] {
    Duty12p5 = 2'd0,
    Duty25   = 2'd1,
    Duty50   = 2'd2,
    Duty75   = 2'd3
  } duty_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StPlay = 1'b1
  } chan_state_e;

  // Period in clock cycles for semitone 1..12 at the given octave
  function automatic int unsigned calc_period(input int unsigned clk_fre,
                                              input int unsigned semi,
                                              input int unsigned oct);
    return (clk_fre / BaseHz[semi-1]) >> oct;
  endfunction

endpackage

// File: rtl/music_tone_chan.sv
// One tone channel: note decode, single-entry pending slot, IDLE/PLAY FSM,
// free-running period counter and duty compare.
// Optional macro MUSIC_TONE_DUTY_EN adds a per-note duty selector.
module music_tone_chan import music_pkg::*; #(
  parameter int unsigned CLK_FRE  = 50_000_000,
  parameter int unsigned OCTAVES  = 4,
  parameter int unsigned PERIOD_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CodeW-1:0] note_code_i,
  input  logic             note_valid_i,
  output logic             note_ready_o,
  input  logic             mute_i,
`ifdef MUSIC_TONE_DUTY_EN
  input  logic [DutyW-1:0] duty_sel_i,
`endif
  output logic             tone_o,
  output logic             active_o
);

  // Elaboration-time period table indexed by [octave][semitone-1]
  logic [PERIOD_W-1:0] period_tbl [OCTAVES][NumSemis];
  for (genvar o = 0; o < OCTAVES; o++) begin : g_oct
    for (genvar s = 0; s < NumSemis; s++) begin : g_semi
      localparam int unsigned Period = calc_period(CLK_FRE, s + 1, o);
      assign period_tbl[o][s] = PERIOD_W'(Period);
    end
  end

  chan_state_e         state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                pend_vld_q, pend_vld_d;
  logic                pend_rest_q, pend_rest_d;
  logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
`ifdef MUSIC_TONE_DUTY_EN
  duty_e               duty_q, duty_d;
  duty_e               pend_duty_q, pend_duty_d;
`endif

  logic                dec_hit;
  logic [PERIOD_W-1:0] dec_period;
  logic                wrap;
  logic                take_pend;
  logic                accept;
  logic [PERIOD_W-1:0] thresh;

  // Decode the incoming note; no table hit means REST
  always_comb begin
    dec_hit    = 1'b0;
    dec_period = '0;
    for (int o = 0; o < OCTAVES; o++) begin
      for (int s = 0; s < NumSemis; s++) begin
        if (int'(note_code_i[CodeW-1:SemiW]) == o &&
            note_code_i[SemiW-1:0] == SemiW'(s + 1)) begin
          dec_hit    = 1'b1;
          dec_period = period_tbl[o][s];
        end
      end
    end
  end

  // Next-state for FSM, counter and pending slot
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    period_d      = period_q;
    pend_vld_d    = pend_vld_q;
    pend_rest_d   = pend_rest_q;
    pend_period_d = pend_period_q;
`ifdef MUSIC_TONE_DUTY_EN
    duty_d        = duty_q;
    pend_duty_d   = pend_duty_q;
`endif
    take_pend     = 1'b0;
    wrap          = (cnt_q == period_q - PERIOD_W'(1));

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (pend_vld_q) begin
          take_pend = 1'b1;
          if (!pend_rest_q) begin
            state_d  = StPlay;
            period_d = pend_period_q;
`ifdef MUSIC_TONE_DUTY_EN
            duty_d   = pend_duty_q;
`endif
          end
        end
      end
      StPlay: begin
        if (wrap) begin
          cnt_d = '0;
          // Only a note already pending before this edge is applied here
          if (pend_vld_q) begin
            take_pend = 1'b1;
            if (pend_rest_q) begin
              state_d = StIdle;
            end else begin
              period_d = pend_period_q;
`ifdef MUSIC_TONE_DUTY_EN
              duty_d   = pend_duty_q;
`endif
            end
          end
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Accept and consume are exclusive: accept needs an empty slot
    accept = note_valid_i & ~pend_vld_q;
    if (take_pend) pend_vld_d = 1'b0;
    if (accept) begin
      pend_vld_d    = 1'b1;
      pend_rest_d   = ~dec_hit;
      pend_period_d = dec_period;
`ifdef MUSIC_TONE_DUTY_EN
      pend_duty_d   = duty_e'(duty_sel_i);
`endif
    end
  end

  // High-phase length for the current note
  always_comb begin
`ifdef MUSIC_TONE_DUTY_EN
    unique case (duty_q)
      Duty12p5: thresh = period_q >> 3;
      Duty25:   thresh = period_q >> 2;
      Duty50:   thresh = period_q >> 1;
      Duty75:   thresh = period_q - (period_q >> 2);
      default:  thresh = period_q >> 1;
    endcase
`else
    thresh = period_q >> 1;
`endif
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      period_q      <= '0;
      pend_vld_q    <= 1'b0;
      pend_rest_q   <= 1'b0;
      pend_period_q <= '0;
`ifdef MUSIC_TONE_DUTY_EN
      duty_q        <= Duty50;
      pend_duty_q   <= Duty50;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      pend_vld_q    <= pend_vld_d;
      pend_rest_q   <= pend_rest_d;
      pend_period_q <= pend_period_d;
`ifdef MUSIC_TONE_DUTY_EN
      duty_q        <= duty_d;
      pend_duty_q   <= pend_duty_d;
`endif
    end
  end

  assign note_ready_o = ~pend_vld_q;
  assign active_o     = (state_q == StPlay);
  assign tone_o       = active_o & (cnt_q < thresh) & ~mute_i;

endmodule

// File: rtl/music_tone_gen.sv
// Multi-channel square-wave tone generator: CHANNELS independent tone
// channels plus a registered count of channels currently driving high.
// Optional macro MUSIC_TONE_DUTY_EN adds the duty_sel input.
module music_tone_gen import music_pkg::*; #(
  parameter int unsigned CLK_FRE  = 50_000_000,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned OCTAVES  = 4,
  parameter int unsigned PERIOD_W = 20,
  localparam int unsigned MixW    = $clog2(CHANNELS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CodeW*CHANNELS-1:0] note_code,
  input  logic [CHANNELS-1:0]       note_valid,
  output logic [CHANNELS-1:0]       note_ready,
  input  logic                      mute,
`ifdef MUSIC_TONE_DUTY_EN
  input  logic [DutyW*CHANNELS-1:0] duty_sel,
`endif
  output logic [CHANNELS-1:0]       tone_out,
  output logic [CHANNELS-1:0]       active,
  output logic [MixW-1:0]           mix_out
);

  logic [MixW-1:0] mix_q, mix_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    music_tone_chan #(
      .CLK_FRE  (CLK_FRE),
      .OCTAVES  (OCTAVES),
      .PERIOD_W (PERIOD_W)
    ) u_chan (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .note_code_i  (note_code[c*CodeW +: CodeW]),
      .note_valid_i (note_valid[c]),
      .note_ready_o (note_ready[c]),
      .mute_i       (mute),
`ifdef MUSIC_TONE_DUTY_EN
      .duty_sel_i   (duty_sel[c*DutyW +: DutyW]),
`endif
      .tone_o       (tone_out[c]),
      .active_o     (active[c])
    );
  end

  // Popcount of this cycle's tone outputs
  always_comb begin
    mix_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mix_d = mix_d + MixW'(tone_out[c]);
    end
  end

  // Mix register, one cycle behind tone_out
  always_ff @(posedge clk) begin
    if (!rst_n) mix_q <= '0;
    else        mix_q <= mix_d;
  end

  assign mix_out = mix_q;

endmodule
